// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, single-outstanding memory read, small return FIFO, decoder delivery pulses.
// Static JAL redirection; flush clears the FIFO and turns an in-flight read into a discard.
module instr_fetch #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_instr,
  output logic        IF_success,
  output logic [31:0] instr,
  output logic [31:0] fetch_pc
);

  localparam int unsigned PW   = $clog2(QUEUE_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d, addr_q, addr_d, instr_q, instr_d, fpc_q, fpc_d;
  logic          req_q, req_d, succ_q, succ_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [31:0]   q_instr [QUEUE_DEPTH];
  logic [31:0]   q_pc    [QUEUE_DEPTH];
  logic          push, pop;
  logic [31:0]   jal_imm, next_pc;

  assign jal_imm = {{12{mem_instr[31]}}, mem_instr[19:12], mem_instr[20], mem_instr[30:21], 1'b0};
  assign next_pc = (mem_instr[6:0] == 7'b1101111) ? addr_q + jal_imm : addr_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    succ_d  = 1'b0;
    instr_d = instr_q;
    fpc_d   = fpc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (rdy) begin
      if (flush) begin
        // the outstanding read, if any, must still be drained from memory
        head_d = '0;
        tail_d = '0;
        cnt_d  = '0;
        pc_d   = flush_pc;
        if (state_q != IDLE) begin
          if (mem_done) begin
            state_d = IDLE;
            req_d   = 1'b0;
          end else begin
            state_d = DISCARD;
          end
        end
      end else begin
        case (state_q)
          IDLE: if (cnt_q < FULL) begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            state_d = WAIT;
          end
          WAIT: if (mem_done) begin
            push    = 1'b1;
            pc_d    = next_pc;
            req_d   = 1'b0;
            state_d = IDLE;
          end
          DISCARD: if (mem_done) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
        if (!stall && cnt_q != '0) begin
          pop     = 1'b1;
          succ_d  = 1'b1;
          instr_d = q_instr[head_q];
          fpc_d   = q_pc[head_q];
          head_d  = head_q + PW'(1);
        end
        if (push) tail_d = tail_q + PW'(1);
        cnt_d = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      req_q   <= 1'b0;
      succ_q  <= 1'b0;
      instr_q <= '0;
      fpc_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      succ_q  <= succ_d;
      instr_q <= instr_d;
      fpc_q   <= fpc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail_q] <= mem_instr;
      q_pc[tail_q]    <= addr_q;
    end
  end

  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign IF_success = succ_q;
  assign instr      = instr_q;
  assign fetch_pc   = fpc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cycle table with hand-computed outputs, then
// multi-cycle sequences driven by a simple latency-configurable memory responder.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst, rdy, stall, flush, mem_done;
  logic [31:0] flush_pc, mem_instr;
  logic        mem_req, IF_success;
  logic [31:0] mem_addr, instr, fetch_pc;

  instr_fetch #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_instr(mem_instr),
    .IF_success(IF_success), .instr(instr), .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, stall, flush;
    logic [31:0] fpc;
    logic        done;
    logic [31:0] minstr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_succ;
    logic [31:0] e_fpc, e_instr;
  } vec_t;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  bit          mem_en, jal_on, req_prev;
  int          mem_lat, lat_cnt;
  logic [31:0] jal_at, jal_word;
  logic [31:0] reqs[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic [31:0] fp,
                              input logic d, input logic [31:0] mi, input logic er,
                              input logic [31:0] ea, input logic es, input logic [31:0] ef,
                              input logic [31:0] ei);
    vec_t v;
    v.rdy = r; v.stall = s; v.flush = f; v.fpc = fp; v.done = d; v.minstr = mi;
    v.e_req = er; v.e_addr = ea; v.e_succ = es; v.e_fpc = ef; v.e_instr = ei;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (jal_on && a == jal_at) return jal_word;
    return {a[23:0], 8'h13};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change at posedge+1; responder acts at negedge; outputs sampled at posedge+1.
  task automatic step();
    @(negedge clk);
    if (mem_en) begin
      mem_done = 1'b0;
      if (mem_req && rdy) begin
        lat_cnt++;
        if (lat_cnt >= mem_lat) begin
          mem_done  = 1'b1;
          mem_instr = mem_word(mem_addr);
          lat_cnt   = 0;
        end
      end else if (!mem_req) begin
        lat_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    if (mem_req && !req_prev) reqs.push_back(mem_addr);
    req_prev = mem_req;
    if (IF_success) begin
      got_pc.push_back(fetch_pc);
      got_instr.push_back(instr);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = '0;
    mem_done = 1'b0; mem_instr = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    reqs.delete(); got_pc.delete(); got_instr.delete();
    req_prev = 1'b0; lat_cnt = 0;
  endtask

  vec_t tbl[19];

  initial begin
    tbl[0]  = mk(1,0,0,32'h0,  0,32'h0,        1,32'h0,  0,32'h0,  32'h0);
    tbl[1]  = mk(1,0,0,32'h0,  1,32'h13,       0,32'h0,  0,32'h0,  32'h0);
    tbl[2]  = mk(1,0,0,32'h0,  0,32'h0,        1,32'h4,  1,32'h0,  32'h13);
    tbl[3]  = mk(1,0,0,32'h0,  1,32'h0100006F, 0,32'h4,  0,32'h0,  32'h13);
    tbl[4]  = mk(1,0,0,32'h0,  0,32'h0,        1,32'h14, 1,32'h4,  32'h0100006F);
    tbl[5]  = mk(1,1,0,32'h0,  1,32'hFFDFF06F, 0,32'h14, 0,32'h4,  32'h0100006F);
    tbl[6]  = mk(1,1,0,32'h0,  0,32'h0,        1,32'h10, 0,32'h4,  32'h0100006F);
    tbl[7]  = mk(0,0,0,32'h0,  0,32'h0,        1,32'h10, 0,32'h4,  32'h0100006F);
    tbl[8]  = mk(1,0,0,32'h0,  1,32'h00001013, 0,32'h10, 1,32'h14, 32'hFFDFF06F);
    tbl[9]  = mk(1,0,1,32'h100,0,32'h0,        0,32'h10, 0,32'h14, 32'hFFDFF06F);
    tbl[10] = mk(1,0,0,32'h0,  0,32'h0,        1,32'h100,0,32'h14, 32'hFFDFF06F);
    tbl[11] = mk(1,0,1,32'h180,0,32'h0,        1,32'h100,0,32'h14, 32'hFFDFF06F);
    tbl[12] = mk(1,0,1,32'h200,0,32'h0,        1,32'h100,0,32'h14, 32'hFFDFF06F);
    tbl[13] = mk(1,0,0,32'h0,  1,32'h0100006F, 0,32'h100,0,32'h14, 32'hFFDFF06F);
    tbl[14] = mk(1,0,0,32'h0,  0,32'h0,        1,32'h200,0,32'h14, 32'hFFDFF06F);
    tbl[15] = mk(1,0,1,32'h300,1,32'h13,       0,32'h200,0,32'h14, 32'hFFDFF06F);
    tbl[16] = mk(1,0,0,32'h0,  0,32'h0,        1,32'h300,0,32'h14, 32'hFFDFF06F);
    tbl[17] = mk(1,0,0,32'h0,  1,32'h00030013, 0,32'h300,0,32'h14, 32'hFFDFF06F);
    tbl[18] = mk(1,0,0,32'h0,  0,32'h0,        1,32'h304,1,32'h300,32'h00030013);

    mem_en = 1'b0; jal_on = 1'b0; mem_lat = 1; jal_at = '0; jal_word = '0;
    do_reset();
    check("reset_outputs", {29'(0), mem_req, IF_success, 1'b0} | mem_addr | instr | fetch_pc, 32'h0);

    foreach (tbl[i]) begin
      rdy = tbl[i].rdy; stall = tbl[i].stall; flush = tbl[i].flush; flush_pc = tbl[i].fpc;
      mem_done = tbl[i].done; mem_instr = tbl[i].minstr;
      step();
      vec_cnt++;
      if (mem_req !== tbl[i].e_req || mem_addr !== tbl[i].e_addr || IF_success !== tbl[i].e_succ ||
          fetch_pc !== tbl[i].e_fpc || instr !== tbl[i].e_instr) begin
        err_cnt++;
        $display("FAIL vec%0d: req=%b addr=%h succ=%b pc=%h instr=%h, expected req=%b addr=%h succ=%b pc=%h instr=%h",
                 i, mem_req, mem_addr, IF_success, fetch_pc, instr,
                 tbl[i].e_req, tbl[i].e_addr, tbl[i].e_succ, tbl[i].e_fpc, tbl[i].e_instr);
      end
    end
    mem_done = 1'b0; flush = 1'b0; stall = 1'b0; rdy = 1'b1;

    // Straight-line code, latency 3
    mem_en = 1'b1; mem_lat = 3;
    do_reset();
    for (int c = 0; c < 100 && got_pc.size() < 3; c++) step();
    if (got_pc.size() < 3) check("straight_timeout", 32'(got_pc.size()), 32'd3);
    else begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("straight_req%0d", k), reqs[k], 32'(4*k));
        check($sformatf("straight_pc%0d", k), got_pc[k], 32'(4*k));
        check($sformatf("straight_instr%0d", k), got_instr[k], mem_word(32'(4*k)));
      end
    end

    // Negative JAL at 0 wraps to 0xFFFFFFFC
    mem_lat = 1; jal_on = 1'b1; jal_at = 32'h0; jal_word = 32'hFFDFF06F;
    do_reset();
    for (int c = 0; c < 50 && reqs.size() < 2; c++) step();
    if (reqs.size() < 2) check("jal_neg_timeout", 32'(reqs.size()), 32'd2);
    else check("jal_neg_target", reqs[1], 32'hFFFFFFFC);
    jal_on = 1'b0;

    // Stall fills the FIFO; release gives four back-to-back deliveries
    do_reset();
    stall = 1'b1;
    for (int c = 0; c < 20; c++) step();
    check("full_req_count", 32'(reqs.size()), 32'd4);
    check("full_mem_req", {31'b0, mem_req}, 32'd0);
    check("full_no_delivery", 32'(got_pc.size()), 32'd0);
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("drain_succ%0d", k), {31'b0, IF_success}, 32'd1);
      check($sformatf("drain_pc%0d", k), fetch_pc, 32'(4*k));
    end
    for (int c = 0; c < 30; c++) step();
    check("resume_count_ge8", {31'b0, got_pc.size() >= 8}, 32'd1);
    for (int k = 0; k < got_pc.size(); k++) begin
      if (got_pc[k] !== 32'(4*k) || got_instr[k] !== mem_word(32'(4*k)))
        check($sformatf("resume_seq%0d", k), got_pc[k], 32'(4*k));
    end
    vec_cnt++;

    // rdy low for 5 cycles with two buffered entries
    do_reset();
    stall = 1'b1;
    for (int c = 0; c < 4; c++) step();
    rdy = 1'b0; stall = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("rdy_low_succ%0d", c), {31'b0, IF_success}, 32'd0);
    end
    rdy = 1'b1;
    for (int c = 0; c < 12; c++) step();
    check("rdy_count_ge3", {31'b0, got_pc.size() >= 3}, 32'd1);
    for (int k = 0; k < got_pc.size(); k++) begin
      if (got_pc[k] !== 32'(4*k))
        check($sformatf("rdy_seq%0d", k), got_pc[k], 32'(4*k));
    end
    vec_cnt++;

    // Async reset while waiting on the fetch at 0x8
    do_reset();
    for (int c = 0; c < 5; c++) step();
    mem_lat = 20;
    check("pre_rst_wait", {mem_req, IF_success, 30'(0)} | 32'(mem_addr), {2'b11, 30'h8});
    rst = 1'b1;
    #1;
    check("async_rst_outputs", {29'(0), mem_req, IF_success, 1'b0} | mem_addr | instr | fetch_pc, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; mem_done = 1'b0; lat_cnt = 0; req_prev = 1'b0; mem_lat = 1;
    reqs.delete();
    for (int c = 0; c < 10 && reqs.size() < 1; c++) step();
    if (reqs.size() < 1) check("post_rst_timeout", 32'(reqs.size()), 32'd1);
    else check("post_rst_first_addr", reqs[0], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
